// File: rtl/mmx_wb_stage.sv
// MMX writeback stage: one writeback latch feeding the register file and bypass
// network, plus a per-register pending-write scoreboard that gates dispatch.
module mmx_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_wr,
    input  logic [2:0]  ex_dest,
    input  logic [63:0] ex_data,
    output logic        ex_ready,
    input  logic        stall,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic        issue_wr,
    input  logic [2:0]  issue_dest,
    output logic        issue_ready,
    output logic [7:0]  busy,
    output logic [63:0] writeback_data,
    output logic [2:0]  writeback_select,
    output logic        writeback_enable,
    output logic        fwd_valid,
    output logic [2:0]  fwd_select,
    output logic [63:0] fwd_data
);

    logic             v_q, v_d;
    logic             wr_q, wr_d;
    logic [2:0]       dest_q, dest_d;
    logic [63:0]      data_q, data_d;
    logic [7:0][1:0]  cnt_q, cnt_d;
    logic             issue_ev_s;

    // Outputs derived directly from the latch and scoreboard
    always_comb begin
        ex_ready         = !stall;
        writeback_enable = v_q & wr_q & !stall & !flush;
        writeback_data   = data_q;
        writeback_select = dest_q;
        fwd_valid        = v_q & wr_q;
        fwd_select       = dest_q;
        fwd_data         = data_q;
        issue_ready      = (cnt_q[issue_dest] != 2'd3);
        issue_ev_s       = issue_valid & issue_wr & issue_ready & !stall & !flush;
        for (int i = 0; i < 8; i++) begin
            busy[i] = (cnt_q[i] != 2'd0);
        end
    end

    // Writeback latch next state: flush kills the entry, stall holds it
    always_comb begin
        v_d    = v_q;
        wr_d   = wr_q;
        dest_d = dest_q;
        data_d = data_q;
        if (flush) begin
            v_d = 1'b0;
        end else if (!stall) begin
            v_d    = ex_valid;
            wr_d   = ex_wr;
            dest_d = ex_dest;
            data_d = ex_data;
        end else begin
            v_d = v_q;
        end
    end

    // Pending-write counters; simultaneous issue and commit cancel out
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 8; i++) begin
            if (flush) begin
                cnt_d[i] = 2'd0;
            end else if (issue_ev_s && (issue_dest == 3'(i)) &&
                         !(writeback_enable && (dest_q == 3'(i)))) begin
                cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (!(issue_ev_s && (issue_dest == 3'(i))) &&
                         writeback_enable && (dest_q == 3'(i))) begin
                cnt_d[i] = (cnt_q[i] != 2'd0) ? (cnt_q[i] - 2'd1) : 2'd0;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q    <= 1'b0;
            wr_q   <= 1'b0;
            dest_q <= 3'd0;
            data_q <= 64'd0;
            cnt_q  <= '0;
        end else begin
            v_q    <= v_d;
            wr_q   <= wr_d;
            dest_q <= dest_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mmx_wb_stage.sv
// Directed self-checking bench for mmx_wb_stage: one task per scenario.
module tb_mmx_wb_stage;

    logic        clk;
    logic        reset;
    logic        ex_valid, ex_wr;
    logic [2:0]  ex_dest;
    logic [63:0] ex_data;
    logic        ex_ready;
    logic        stall, flush;
    logic        issue_valid, issue_wr;
    logic [2:0]  issue_dest;
    logic        issue_ready;
    logic [7:0]  busy;
    logic [63:0] writeback_data;
    logic [2:0]  writeback_select;
    logic        writeback_enable;
    logic        fwd_valid;
    logic [2:0]  fwd_select;
    logic [63:0] fwd_data;

    int compared;
    int mismatched;

    mmx_wb_stage dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_wr(ex_wr), .ex_dest(ex_dest), .ex_data(ex_data),
        .ex_ready(ex_ready), .stall(stall), .flush(flush),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dest(issue_dest),
        .issue_ready(issue_ready), .busy(busy),
        .writeback_data(writeback_data), .writeback_select(writeback_select),
        .writeback_enable(writeback_enable),
        .fwd_valid(fwd_valid), .fwd_select(fwd_select), .fwd_data(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_wr = 1'b0; ex_dest = 3'd0; ex_data = 64'd0;
        stall = 1'b0; flush = 1'b0;
        issue_valid = 1'b0; issue_wr = 1'b0; issue_dest = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        #2;
        compared++; if (writeback_enable !== 1'b0) begin mismatched++; $display("FAIL reset_wb_en: got %b want 0", writeback_enable); end
        compared++; if (writeback_select !== 3'd0) begin mismatched++; $display("FAIL reset_wb_sel: got %0d want 0", writeback_select); end
        compared++; if (writeback_data !== 64'd0) begin mismatched++; $display("FAIL reset_wb_data: got %h want 0", writeback_data); end
        compared++; if (fwd_valid !== 1'b0) begin mismatched++; $display("FAIL reset_fwd_valid: got %b want 0", fwd_valid); end
        compared++; if (busy !== 8'h00) begin mismatched++; $display("FAIL reset_busy: got %h want 00", busy); end
        compared++; if (issue_ready !== 1'b1) begin mismatched++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
        compared++; if (ex_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready); end
        stall = 1'b1;
        #1;
        compared++; if (ex_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ex_ready_stall: got %b want 0", ex_ready); end
        stall = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic_writeback();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 3'd3;
        #1;
        compared++; if (issue_ready !== 1'b1) begin mismatched++; $display("FAIL basic_issue_ready: got %b want 1", issue_ready); end
        step();
        issue_valid = 1'b0; issue_wr = 1'b0;
        ex_valid = 1'b1; ex_wr = 1'b1; ex_dest = 3'd3; ex_data = 64'hDEADBEEF_01234567;
        #1;
        compared++; if (busy !== 8'h08) begin mismatched++; $display("FAIL basic_busy_after_issue: got %h want 08", busy); end
        step();
        ex_valid = 1'b0; ex_wr = 1'b0;
        #1;
        compared++; if (writeback_enable !== 1'b1) begin mismatched++; $display("FAIL basic_wb_en: got %b want 1", writeback_enable); end
        compared++; if (writeback_select !== 3'd3) begin mismatched++; $display("FAIL basic_wb_sel: got %0d want 3", writeback_select); end
        compared++; if (writeback_data !== 64'hDEADBEEF_01234567) begin mismatched++; $display("FAIL basic_wb_data: got %h want deadbeef01234567", writeback_data); end
        compared++; if (fwd_valid !== 1'b1 || fwd_data !== 64'hDEADBEEF_01234567) begin mismatched++; $display("FAIL basic_fwd: got %b/%h want 1/deadbeef01234567", fwd_valid, fwd_data); end
        step();
        compared++; if (busy !== 8'h00) begin mismatched++; $display("FAIL basic_busy_after_commit: got %h want 00", busy); end
        compared++; if (writeback_enable !== 1'b0) begin mismatched++; $display("FAIL basic_wb_once: got %b want 0", writeback_enable); end
    endtask

    task automatic test_stall_hold();
        int pulses;
        pulses = 0;
        ex_valid = 1'b1; ex_wr = 1'b1; ex_dest = 3'd5; ex_data = 64'h0123_4567_89AB_CDEF;
        step();
        ex_valid = 1'b0; ex_wr = 1'b0; ex_data = 64'd0;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            compared++; if (writeback_enable !== 1'b0) begin mismatched++; $display("FAIL stall_wb_en[%0d]: got %b want 0", c, writeback_enable); end
            compared++; if (fwd_valid !== 1'b1 || fwd_select !== 3'd5) begin mismatched++; $display("FAIL stall_fwd[%0d]: got %b/%0d want 1/5", c, fwd_valid, fwd_select); end
            compared++; if (ex_ready !== 1'b0) begin mismatched++; $display("FAIL stall_ex_ready[%0d]: got %b want 0", c, ex_ready); end
            if (writeback_enable === 1'b1) pulses++;
            step();
        end
        stall = 1'b0;
        #1;
        if (writeback_enable === 1'b1) pulses++;
        compared++; if (writeback_select !== 3'd5 || writeback_data !== 64'h0123_4567_89AB_CDEF) begin mismatched++; $display("FAIL stall_release_data: got %0d/%h want 5/0123456789abcdef", writeback_select, writeback_data); end
        step();
        if (writeback_enable === 1'b1) pulses++;
        compared++; if (pulses !== 1) begin mismatched++; $display("FAIL stall_pulse_count: got %0d want 1", pulses); end
    endtask

    task automatic test_saturate();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 3'd2;
        step(); step(); step();
        #1;
        compared++; if (issue_ready !== 1'b0) begin mismatched++; $display("FAIL sat_ready_dest2: got %b want 0", issue_ready); end
        issue_dest = 3'd4;
        #1;
        compared++; if (issue_ready !== 1'b1) begin mismatched++; $display("FAIL sat_ready_dest4: got %b want 1", issue_ready); end
        issue_dest = 3'd2;
        step();
        issue_valid = 1'b0; issue_wr = 1'b0;
        compared++; if (busy !== 8'h04) begin mismatched++; $display("FAIL sat_busy_after_fourth: got %h want 04", busy); end
        ex_valid = 1'b1; ex_wr = 1'b1; ex_dest = 3'd2; ex_data = 64'h2;
        step();
        compared++; if (issue_ready !== 1'b0) begin mismatched++; $display("FAIL sat_ready_pre_commit: got %b want 0", issue_ready); end
        step();
        compared++; if (issue_ready !== 1'b1) begin mismatched++; $display("FAIL sat_ready_after_commit: got %b want 1", issue_ready); end
        step();
        ex_valid = 1'b0; ex_wr = 1'b0;
        #1;
        compared++; if (busy !== 8'h04) begin mismatched++; $display("FAIL sat_busy_cnt1: got %h want 04", busy); end
        step();
        compared++; if (busy !== 8'h00) begin mismatched++; $display("FAIL sat_busy_drained: got %h want 00", busy); end
    endtask

    task automatic test_back_to_back();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 3'd6;
        step();
        issue_valid = 1'b0; issue_wr = 1'b0;
        ex_valid = 1'b1; ex_wr = 1'b1; ex_dest = 3'd6; ex_data = 64'h66;
        step();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 3'd6;
        #1;
        compared++; if (writeback_enable !== 1'b1 || writeback_select !== 3'd6) begin mismatched++; $display("FAIL b2b_commit: got %b/%0d want 1/6", writeback_enable, writeback_select); end
        step();
        issue_valid = 1'b0; issue_wr = 1'b0;
        ex_valid = 1'b0; ex_wr = 1'b0;
        #1;
        compared++; if (busy !== 8'h40) begin mismatched++; $display("FAIL b2b_busy_held: got %h want 40", busy); end
        step();
        compared++; if (busy !== 8'h00) begin mismatched++; $display("FAIL b2b_busy_drained: got %h want 00", busy); end
    endtask

    task automatic test_flush();
        issue_valid = 1'b1; issue_wr = 1'b1;
        for (int r = 0; r < 8; r++) begin
            issue_dest = 3'(r);
            step();
        end
        issue_valid = 1'b0; issue_wr = 1'b0;
        ex_valid = 1'b1; ex_wr = 1'b1; ex_dest = 3'd1; ex_data = 64'h11;
        step();
        compared++; if (busy !== 8'hFF) begin mismatched++; $display("FAIL flush_busy_full: got %h want ff", busy); end
        flush = 1'b1;
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 3'd0;
        #1;
        compared++; if (writeback_enable !== 1'b0) begin mismatched++; $display("FAIL flush_wb_en: got %b want 0", writeback_enable); end
        step();
        flush = 1'b0;
        issue_valid = 1'b0; issue_wr = 1'b0;
        ex_valid = 1'b0; ex_wr = 1'b0;
        #1;
        compared++; if (busy !== 8'h00) begin mismatched++; $display("FAIL flush_busy_clear: got %h want 00", busy); end
        compared++; if (fwd_valid !== 1'b0) begin mismatched++; $display("FAIL flush_fwd_valid: got %b want 0", fwd_valid); end
        compared++; if (writeback_enable !== 1'b0) begin mismatched++; $display("FAIL flush_wb_after: got %b want 0", writeback_enable); end
    endtask

    task automatic test_async_reset();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 3'd0;
        step();
        issue_valid = 1'b0; issue_wr = 1'b0;
        ex_valid = 1'b1; ex_wr = 1'b1; ex_dest = 3'd7; ex_data = 64'hA5A5;
        step();
        ex_valid = 1'b0; ex_wr = 1'b0;
        stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        compared++; if (writeback_enable !== 1'b0) begin mismatched++; $display("FAIL async_wb_en: got %b want 0", writeback_enable); end
        compared++; if (writeback_select !== 3'd0 || writeback_data !== 64'd0) begin mismatched++; $display("FAIL async_wb_sel_data: got %0d/%h want 0/0", writeback_select, writeback_data); end
        compared++; if (fwd_valid !== 1'b0) begin mismatched++; $display("FAIL async_fwd_valid: got %b want 0", fwd_valid); end
        compared++; if (busy !== 8'h00) begin mismatched++; $display("FAIL async_busy: got %h want 00", busy); end
        compared++; if (issue_ready !== 1'b1) begin mismatched++; $display("FAIL async_issue_ready: got %b want 1", issue_ready); end
        compared++; if (ex_ready !== 1'b0) begin mismatched++; $display("FAIL async_ex_ready: got %b want 0", ex_ready); end
        #2;
        reset = 1'b1;
        stall = 1'b0;
        #1;
        compared++; if (writeback_enable !== 1'b0) begin mismatched++; $display("FAIL async_no_pulse: got %b want 0", writeback_enable); end
        step();
        compared++; if (writeback_enable !== 1'b0 || busy !== 8'h00) begin mismatched++; $display("FAIL async_after_edge: got %b/%h want 0/00", writeback_enable, busy); end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_basic_writeback();
        test_stall_hold();
        test_saturate();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mmx_wb_stage.md
MMX_WB_STAGE -- requirements
Module: mmx_wb_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-003 SHALL have port: ex_valid  in  1  execute stage presents a completed MMX instruction.
REQ-004 SHALL have port: ex_wr  in  1  that instruction writes an MMX register.
REQ-005 SHALL have port: ex_dest  in  3  destination MMX register index.
REQ-006 SHALL have port: ex_data  in  64  result data.
REQ-007 SHALL have port: ex_ready  out  1  stage accepts ex_* this cycle.
REQ-008 SHALL have port: stall  in  1  global pipeline stall.
REQ-009 SHALL have port: flush  in  1  discard all in-flight MMX writes.
REQ-010 SHALL have port: issue_valid  in  1  read stage dispatches an instruction.
REQ-011 SHALL have port: issue_wr  in  1  dispatched instruction will write an MMX register.
REQ-012 SHALL have port: issue_dest  in  3  its destination index.
REQ-013 SHALL have port: issue_ready  out  1  dispatch to issue_dest is permitted.
REQ-014 SHALL have port: busy  out  8  per-register pending-write flags.
REQ-015 SHALL have port: writeback_data  out  64  to MMX register file.
REQ-016 SHALL have port: writeback_select  out  3  to MMX register file.
REQ-017 SHALL have port: writeback_enable  out  1  to MMX register file.
REQ-018 SHALL have port: fwd_valid  out  1  bypass entry valid.
REQ-019 SHALL have port: fwd_select  out  3  bypass register index.
REQ-020 SHALL have port: fwd_data  out  64  bypass data.

Function
REQ-021 SHALL hold one writeback latch {v, wr, dest[2:0], data[63:0]}.
REQ-022 SHALL, on a clock edge with stall=0 and flush=0, load v<=ex_valid, wr<=ex_wr, dest<=ex_dest, data<=ex_data.
REQ-023 SHALL, on a clock edge with stall=1 and flush=0, hold the latch unchanged.
REQ-024 SHALL, on a clock edge with flush=1, clear v to 0 regardless of stall or ex_valid (flush wins).
REQ-025 SHALL drive ex_ready = !stall, combinationally.
REQ-026 SHALL drive writeback_enable = v & wr & !stall & !flush, combinationally; writeback_data = data, writeback_select = dest.
REQ-027 SHALL therefore commit each latched write exactly once: one cycle after capture, or on the first cycle stall deasserts.
REQ-028 SHALL drive fwd_valid = v & wr, fwd_select = dest, fwd_data = data, unaffected by stall.
REQ-029 SHALL keep a 2-bit pending counter cnt[i] per register i (0..7).
REQ-030 SHALL define issue event = issue_valid & issue_wr & issue_ready & !stall & !flush.
REQ-031 SHALL define commit event for register i = writeback_enable & (writeback_select == i).
REQ-032 SHALL, per edge: issue only -> cnt+1; commit only -> cnt-1; both on same register -> unchanged.
REQ-033 SHALL saturate cnt at 0 on commit with cnt=0 (no underflow).
REQ-034 SHALL drive issue_ready = (cnt[issue_dest] != 3); issue with issue_ready=0 is ignored.
REQ-035 SHALL drive busy[i] = (cnt[i] != 0).
REQ-036 SHALL, on a clock edge with flush=1, clear all cnt to 0 and not apply any issue or commit that cycle.
REQ-037 SHALL treat ex_valid with ex_wr=0 as latching a non-writing entry: no writeback, fwd_valid=0.

Reset
REQ-038 SHALL, while reset=0, force v=0, wr=0, dest=0, data=0, all cnt=0.
REQ-039 SHALL present after reset: writeback_enable=0, writeback_select=0, writeback_data=0, fwd_valid=0, busy=8'h00, issue_ready=1, ex_ready=!stall.
REQ-040 SHALL, on reset assertion mid-stall or mid-commit, drop the pending write with no writeback pulse after reset.

Verification
REQ-041 SHALL cover: issue dest=3, then ex_valid/ex_wr dest=3 data=64'hDEADBEEF_01234567 -> busy[3]=1 after issue; next cycle writeback_enable=1, select=3, data matches; busy[3]=0 after that edge.
REQ-042 SHALL cover: latch loaded dest=5, stall=1 for 3 cycles -> writeback_enable=0, fwd_valid=1 throughout; stall=0 -> exactly one writeback pulse.
REQ-043 SHALL cover: three issues to dest=2 -> cnt=3, issue_ready=0 for dest=2 and 1 for dest=4; fourth issue ignored; one commit -> issue_ready=1.
REQ-044 SHALL cover: issue and commit to dest=6 same cycle with cnt=1 -> cnt stays 1, busy[6]=1.
REQ-045 SHALL cover: busy=8'hFF, latch valid, flush=1 -> next cycle busy=8'h00, fwd_valid=0, writeback_enable=0 in flush cycle.
REQ-046 SHALL cover: reset=0 asserted asynchronously between edges with v=1 -> outputs reach REQ-039 values before next edge.
